clock_alarm_param: RTL and testbench

- Parametrised time-of-day counter, successor to the fixed 24 h seconds/minutes/hours counter.
- Adds:
  - configurable rollover limits and field widths;
  - run/pause control;
  - synchronous time load;
  - an alarm with timed ring, snooze and acknowledge;
  - 12 h display formatting;
  - a day-rollover pulse.
- Clocked by the 1 Hz tick and sits between the tick generator and the display/annunciator logic.

---
 rtl/clock_alarm_param.sv | 213 +++++++++++++++++++++
 tb/tb_clock_alarm_param.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_alarm_param.sv
// Parametrised time-of-day counter with run/pause, synchronous load, alarm
// (ring / snooze / acknowledge), 12 h display formatting and a day-rollover pulse.
module clock_alarm_param #(
  parameter int SEC_MAX     = 60,
  parameter int MIN_MAX     = 60,
  parameter int HR_MAX      = 24,
  parameter int SW          = 6,
  parameter int MW          = 6,
  parameter int HW          = 5,
  parameter int RING_SECS   = 30,
  parameter int SNOOZE_MINS = 5
) (
  input  logic          Clk_1sec,
  input  logic          reset,
  input  logic          run,
  input  logic          load,
  input  logic [SW-1:0] load_sec,
  input  logic [MW-1:0] load_min,
  input  logic [HW-1:0] load_hr,
  input  logic          alm_set,
  input  logic [MW-1:0] alm_min,
  input  logic [HW-1:0] alm_hr,
  input  logic          alm_en,
  input  logic          snooze,
  input  logic          alm_ack,
  input  logic          fmt12,
  output logic [SW-1:0] seconds,
  output logic [MW-1:0] minutes,
  output logic [HW-1:0] hours,
  output logic [HW-1:0] disp_hours,
  output logic          pm,
  output logic          day_tick,
  output logic          ringing
);

  localparam logic [SW-1:0] SEC_LAST = SW'(SEC_MAX - 1);
  localparam logic [MW-1:0] MIN_LAST = MW'(MIN_MAX - 1);
  localparam logic [HW-1:0] HR_LAST  = HW'(HR_MAX - 1);

  localparam int SNZ_TICKS = SNOOZE_MINS * SEC_MAX;
  localparam int SNZ_W     = $clog2(SNZ_TICKS + 1);
  localparam int RING_W    = (RING_SECS > 1) ? $clog2(RING_SECS) : 1;

  localparam logic [SNZ_W-1:0]  SNZ_INIT  = SNZ_W'(SNZ_TICKS);
  localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_SECS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } almState_t;

  logic [SW-1:0]     sec_q, sec_d;
  logic [MW-1:0]     min_q, min_d;
  logic [HW-1:0]     hr_q, hr_d;
  logic              dayTick_q, dayTick_d;
  logic [MW-1:0]     almMin_q, almMin_d;
  logic [HW-1:0]     almHr_q, almHr_d;
  logic [RING_W-1:0] ringCnt_q, ringCnt_d;
  logic [SNZ_W-1:0]  snzCnt_q, snzCnt_d;
  almState_t         state_q, state_d;
  logic              ringing_q;
  logic              incr;
  logic              timeMatch;
  logic [HW-1:0]     dispHr;
  logic              pmFlag;

  assign incr = run && !load;

  // Time next-state: load clamps out-of-range fields to 0, increment carries upward.
  always_comb begin
    sec_d     = sec_q;
    min_d     = min_q;
    hr_d      = hr_q;
    dayTick_d = 1'b0;
    if (load) begin
      sec_d = (load_sec > SEC_LAST) ? '0 : load_sec;
      min_d = (load_min > MIN_LAST) ? '0 : load_min;
      hr_d  = (load_hr  > HR_LAST)  ? '0 : load_hr;
    end else if (run) begin
      if (sec_q >= SEC_LAST) begin
        sec_d = '0;
        if (min_q >= MIN_LAST) begin
          min_d = '0;
          if (hr_q >= HR_LAST) begin
            hr_d      = '0;
            dayTick_d = 1'b1;
          end else begin
            hr_d = hr_q + 1'b1;
          end
        end else begin
          min_d = min_q + 1'b1;
        end
      end else begin
        sec_d = sec_q + 1'b1;
      end
    end
  end

  always_comb begin
    almMin_d = almMin_q;
    almHr_d  = almHr_q;
    if (alm_set) begin
      almMin_d = (alm_min > MIN_LAST) ? '0 : alm_min;
      almHr_d  = (alm_hr  > HR_LAST)  ? '0 : alm_hr;
    end
  end

  // Only an increment edge landing exactly on the alarm minute starts a ring.
  assign timeMatch = incr && (sec_d == '0) && (min_d == almMin_q) && (hr_d == almHr_q);

  always_comb begin
    state_d   = state_q;
    ringCnt_d = ringCnt_q;
    snzCnt_d  = snzCnt_q;
    if (!alm_en) begin
      state_d   = IDLE;
      ringCnt_d = '0;
      snzCnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!alm_set && timeMatch) begin
            state_d   = RING;
            ringCnt_d = '0;
          end
        end
        RING: begin
          if (alm_set || alm_ack) begin
            state_d   = IDLE;
            ringCnt_d = '0;
          end else if (snooze) begin
            state_d   = SNOOZE;
            ringCnt_d = '0;
            snzCnt_d  = SNZ_INIT;
          end else if (ringCnt_q >= RING_LAST) begin
            state_d   = IDLE;
            ringCnt_d = '0;
          end else begin
            ringCnt_d = ringCnt_q + 1'b1;
          end
        end
        SNOOZE: begin
          if (alm_set || alm_ack) begin
            state_d  = IDLE;
            snzCnt_d = '0;
          end else if (snzCnt_q <= SNZ_W'(1)) begin
            state_d   = RING;
            ringCnt_d = '0;
            snzCnt_d  = '0;
          end else begin
            snzCnt_d = snzCnt_q - 1'b1;
          end
        end
        default: begin
          state_d   = IDLE;
          ringCnt_d = '0;
          snzCnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk_1sec or posedge reset) begin
    if (reset) begin
      sec_q     <= '0;
      min_q     <= '0;
      hr_q      <= '0;
      dayTick_q <= 1'b0;
      almMin_q  <= '0;
      almHr_q   <= '0;
      ringCnt_q <= '0;
      snzCnt_q  <= '0;
      state_q   <= IDLE;
      ringing_q <= 1'b0;
    end else begin
      sec_q     <= sec_d;
      min_q     <= min_d;
      hr_q      <= hr_d;
      dayTick_q <= dayTick_d;
      almMin_q  <= almMin_d;
      almHr_q   <= almHr_d;
      ringCnt_q <= ringCnt_d;
      snzCnt_q  <= snzCnt_d;
      state_q   <= state_d;
      ringing_q <= (state_d == RING);
    end
  end

  // 12 h view only makes sense for a 24-hour day; other day lengths pass through.
  always_comb begin
    dispHr = hr_q;
    pmFlag = 1'b0;
    if (fmt12 && (HR_MAX == 24)) begin
      pmFlag = (hr_q >= HW'(12));
      if (hr_q >= HW'(12)) begin
        dispHr = hr_q - HW'(12);
      end
      if (dispHr == '0) begin
        dispHr = HW'(12);
      end
    end
  end

  assign seconds    = sec_q;
  assign minutes    = min_q;
  assign hours      = hr_q;
  assign disp_hours = dispHr;
  assign pm         = pmFlag;
  assign day_tick   = dayTick_q;
  assign ringing    = ringing_q;

endmodule

// File: tb/tb_clock_alarm_param.sv
// Directed bench for clock_alarm_param: rollover, load clamping, pause,
// alarm ring/snooze/ack, 12 h display and asynchronous reset.
module tb_clock_alarm_param;

  localparam int SW = 7;
  localparam int MW = 7;
  localparam int HW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          run;
  logic          load;
  logic [SW-1:0] load_sec;
  logic [MW-1:0] load_min;
  logic [HW-1:0] load_hr;
  logic          alm_set;
  logic [MW-1:0] alm_min;
  logic [HW-1:0] alm_hr;
  logic          alm_en;
  logic          snooze;
  logic          alm_ack;
  logic          fmt12;
  logic [SW-1:0] seconds;
  logic [MW-1:0] minutes;
  logic [HW-1:0] hours;
  logic [HW-1:0] disp_hours;
  logic          pm;
  logic          day_tick;
  logic          ringing;

  int checkCnt = 0;
  int passCnt  = 0;

  clock_alarm_param #(
    .SEC_MAX(60), .MIN_MAX(60), .HR_MAX(24),
    .SW(SW), .MW(MW), .HW(HW),
    .RING_SECS(30), .SNOOZE_MINS(5)
  ) dut (
    .Clk_1sec(clk), .reset(reset), .run(run), .load(load),
    .load_sec(load_sec), .load_min(load_min), .load_hr(load_hr),
    .alm_set(alm_set), .alm_min(alm_min), .alm_hr(alm_hr),
    .alm_en(alm_en), .snooze(snooze), .alm_ack(alm_ack), .fmt12(fmt12),
    .seconds(seconds), .minutes(minutes), .hours(hours),
    .disp_hours(disp_hours), .pm(pm), .day_tick(day_tick), .ringing(ringing)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setLoad(input int h, input int m, input int s);
    load     = 1'b1;
    load_hr  = HW'(h);
    load_min = MW'(m);
    load_sec = SW'(s);
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b0; load = 1'b0; load_sec = '0; load_min = '0; load_hr = '0;
    alm_set = 1'b0; alm_min = '0; alm_hr = '0; alm_en = 1'b0; snooze = 1'b0;
    alm_ack = 1'b0; fmt12 = 1'b0;
    step();
    step();
    checkCnt++;
    if ({hours, minutes, seconds, day_tick, ringing} !== '0) begin
      $display("FAIL reset_state: got %0d:%0d:%0d dt=%0d ring=%0d expected 0:0:0 dt=0 ring=0",
               hours, minutes, seconds, day_tick, ringing);
    end else passCnt++;
    reset = 1'b0;
    setLoad(13, 45, 8);
    run = 1'b1;
    step();
    load = 1'b0;
    step();
    step();
    checkCnt++;
    if ({hours, minutes, seconds} !== {5'd13, 7'd45, 7'd10}) begin
      $display("FAIL reset_precount: got %0d:%0d:%0d expected 13:45:10", hours, minutes, seconds);
    end else passCnt++;
    #3;
    reset = 1'b1;
    #1;
    checkCnt++;
    if ({hours, minutes, seconds, day_tick, ringing} !== '0) begin
      $display("FAIL reset_async: got %0d:%0d:%0d dt=%0d ring=%0d expected all 0 before edge",
               hours, minutes, seconds, day_tick, ringing);
    end else passCnt++;
    reset = 1'b0;
    run = 1'b0;
  endtask

  task automatic test_rollover();
    setLoad(23, 59, 58);
    run = 1'b1;
    step();
    load = 1'b0;
    step();
    checkCnt++;
    if ({hours, minutes, seconds, day_tick} !== {5'd23, 7'd59, 7'd59, 1'b0}) begin
      $display("FAIL roll_2359: got %0d:%0d:%0d dt=%0d expected 23:59:59 dt=0",
               hours, minutes, seconds, day_tick);
    end else passCnt++;
    step();
    checkCnt++;
    if ({hours, minutes, seconds, day_tick} !== {5'd0, 7'd0, 7'd0, 1'b1}) begin
      $display("FAIL roll_midnight: got %0d:%0d:%0d dt=%0d expected 0:0:0 dt=1",
               hours, minutes, seconds, day_tick);
    end else passCnt++;
    step();
    checkCnt++;
    if ({hours, minutes, seconds, day_tick} !== {5'd0, 7'd0, 7'd1, 1'b0}) begin
      $display("FAIL roll_after: got %0d:%0d:%0d dt=%0d expected 0:0:1 dt=0",
               hours, minutes, seconds, day_tick);
    end else passCnt++;
    setLoad(23, 59, 59);
    step();
    setLoad(0, 0, 0);
    step();
    checkCnt++;
    if ({hours, minutes, seconds, day_tick} !== {5'd0, 7'd0, 7'd0, 1'b0}) begin
      $display("FAIL load_no_daytick: got %0d:%0d:%0d dt=%0d expected 0:0:0 dt=0",
               hours, minutes, seconds, day_tick);
    end else passCnt++;
    load = 1'b0;
    run = 1'b0;
  endtask

  task automatic test_load_clamp();
    setLoad(10, 70, 99);
    step();
    checkCnt++;
    if ({hours, minutes, seconds} !== {5'd10, 7'd0, 7'd0}) begin
      $display("FAIL load_clamp_ms: got %0d:%0d:%0d expected 10:0:0", hours, minutes, seconds);
    end else passCnt++;
    setLoad(24, 59, 30);
    step();
    checkCnt++;
    if ({hours, minutes, seconds} !== {5'd0, 7'd59, 7'd30}) begin
      $display("FAIL load_clamp_hr: got %0d:%0d:%0d expected 0:59:30", hours, minutes, seconds);
    end else passCnt++;
    load = 1'b0;
    run = 1'b0;
    repeat (5) step();
    checkCnt++;
    if ({hours, minutes, seconds, day_tick} !== {5'd0, 7'd59, 7'd30, 1'b0}) begin
      $display("FAIL pause_hold: got %0d:%0d:%0d dt=%0d expected 0:59:30 dt=0",
               hours, minutes, seconds, day_tick);
    end else passCnt++;
    run = 1'b1;
    repeat (30) step();
    checkCnt++;
    if ({hours, minutes, seconds} !== {5'd1, 7'd0, 7'd0}) begin
      $display("FAIL hour_carry: got %0d:%0d:%0d expected 1:0:0", hours, minutes, seconds);
    end else passCnt++;
    run = 1'b0;
  endtask

  task automatic test_alarm_ring();
    int n;
    alm_en  = 1'b1;
    alm_set = 1'b1;
    alm_hr  = 5'd7;
    alm_min = 7'd30;
    setLoad(7, 29, 58);
    run = 1'b1;
    step();
    alm_set = 1'b0;
    load = 1'b0;
    step();
    checkCnt++;
    if (ringing !== 1'b0) begin
      $display("FAIL ring_early: got %0d expected 0", ringing);
    end else passCnt++;
    step();
    checkCnt++;
    if ({hours, minutes, seconds, ringing} !== {5'd7, 7'd30, 7'd0, 1'b1}) begin
      $display("FAIL ring_start: got %0d:%0d:%0d ring=%0d expected 7:30:0 ring=1",
               hours, minutes, seconds, ringing);
    end else passCnt++;
    n = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (ringing !== 1'b1) break;
      n++;
    end
    checkCnt++;
    if (n !== 30) begin
      $display("FAIL ring_length: got %0d edges expected 30", n);
    end else passCnt++;
    checkCnt++;
    if (ringing !== 1'b0) begin
      $display("FAIL ring_autostop: got %0d expected 0", ringing);
    end else passCnt++;
  endtask

  task automatic test_snooze();
    int n;
    bit reRang;
    setLoad(7, 29, 59);
    step();
    load = 1'b0;
    step();
    checkCnt++;
    if (ringing !== 1'b1) begin
      $display("FAIL snz_ring: got %0d expected 1", ringing);
    end else passCnt++;
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    checkCnt++;
    if (ringing !== 1'b0) begin
      $display("FAIL snz_enter: got %0d expected 0", ringing);
    end else passCnt++;
    n = 1;
    for (int i = 0; i < 400; i++) begin
      step();
      if (ringing === 1'b1) break;
      n++;
    end
    checkCnt++;
    if (n !== 300 || ringing !== 1'b1) begin
      $display("FAIL snz_length: got %0d quiet edges ring=%0d expected 300 ring=1", n, ringing);
    end else passCnt++;
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    repeat (10) step();
    alm_ack = 1'b1;
    step();
    alm_ack = 1'b0;
    reRang = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (ringing !== 1'b0) reRang = 1'b1;
    end
    checkCnt++;
    if (reRang !== 1'b0) begin
      $display("FAIL snz_ack: got rering=%0d expected 0", reRang);
    end else passCnt++;
    setLoad(7, 29, 59);
    step();
    load = 1'b0;
    step();
    alm_ack = 1'b1;
    step();
    alm_ack = 1'b0;
    checkCnt++;
    if (ringing !== 1'b0) begin
      $display("FAIL ring_ack: got %0d expected 0", ringing);
    end else passCnt++;
    run = 1'b0;
  endtask

  task automatic test_fmt12();
    logic [HW-1:0] hrTab [6]  = '{5'd0, 5'd12, 5'd23, 5'd1, 5'd13, 5'd11};
    logic [HW-1:0] dispTab [6] = '{5'd12, 5'd12, 5'd11, 5'd1, 5'd1, 5'd11};
    logic          pmTab [6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    fmt12 = 1'b1;
    run = 1'b0;
    for (int i = 0; i < 6; i++) begin
      setLoad(int'(hrTab[i]), 15, 0);
      step();
      checkCnt++;
      if (disp_hours !== dispTab[i] || pm !== pmTab[i]) begin
        $display("FAIL fmt12_h%0d: got disp=%0d pm=%0d expected disp=%0d pm=%0d",
                 hrTab[i], disp_hours, pm, dispTab[i], pmTab[i]);
      end else passCnt++;
    end
    load = 1'b0;
    fmt12 = 1'b0;
    #1;
    checkCnt++;
    if (disp_hours !== 5'd11 || pm !== 1'b0) begin
      $display("FAIL fmt24: got disp=%0d pm=%0d expected disp=11 pm=0", disp_hours, pm);
    end else passCnt++;
  endtask

  task automatic test_alm_disable();
    alm_en  = 1'b1;
    alm_set = 1'b1;
    alm_hr  = 5'd8;
    alm_min = 7'd0;
    setLoad(7, 59, 59);
    run = 1'b1;
    step();
    alm_set = 1'b0;
    load = 1'b0;
    step();
    checkCnt++;
    if ({hours, minutes, seconds, ringing} !== {5'd8, 7'd0, 7'd0, 1'b1}) begin
      $display("FAIL dis_ring: got %0d:%0d:%0d ring=%0d expected 8:0:0 ring=1",
               hours, minutes, seconds, ringing);
    end else passCnt++;
    repeat (3) step();
    alm_en = 1'b0;
    step();
    checkCnt++;
    if (ringing !== 1'b0) begin
      $display("FAIL dis_drop: got %0d expected 0", ringing);
    end else passCnt++;
    alm_en = 1'b1;
    repeat (3) step();
    checkCnt++;
    if (ringing !== 1'b0) begin
      $display("FAIL dis_reenable: got %0d expected 0", ringing);
    end else passCnt++;
    run = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rollover();
    test_load_clamp();
    test_alarm_ring();
    test_snooze();
    test_fmt12();
    test_alm_disable();
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
